// File: rtl/tlc_pkg.sv
// Shared phase encodings and width helper for the intersection sequencer.
package tlc_pkg;

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2,
    PH_FLASH   = 2'd3
  } phase_e;

  // Bits needed to hold the range 0..max_val (never less than 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Loadable tick counter with synchronous clear and terminal-count compare.
// Shared by every phase and by the flash blink.
module tlc_phase_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_tick,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_count,
  output logic         o_at_term
);

  logic [W-1:0] r_count;

  // Clear has priority over load, load over counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_tick) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_at_term = (r_count == i_term);

endmodule

// File: rtl/traffic_intersection_controller.sv
// Round-robin multi-approach traffic light sequencer with latched requests
// that shorten green after a minimum time, and a blinking-yellow flash mode.
module traffic_intersection_controller
  import tlc_pkg::*;
#(
  parameter int unsigned N_DIR           = 2,
  parameter int unsigned GREEN_TICKS     = 8,
  parameter int unsigned MIN_GREEN_TICKS = 4,
  parameter int unsigned YELLOW_TICKS    = 3,
  parameter int unsigned ALL_RED_TICKS   = 2,
  parameter int unsigned FLASH_TICKS     = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     tick_en,
  input  logic [N_DIR-1:0]         req,
  input  logic                     flash_mode,
  output logic [N_DIR-1:0]         red,
  output logic [N_DIR-1:0]         yellow,
  output logic [N_DIR-1:0]         green,
  output logic [$clog2(N_DIR)-1:0] active_dir,
  output logic [1:0]               phase
);

  localparam int unsigned DW    = $clog2(N_DIR);
  localparam int unsigned MAX_A = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
  localparam int unsigned MAX_B = (ALL_RED_TICKS > FLASH_TICKS) ? ALL_RED_TICKS : FLASH_TICKS;
  localparam int unsigned MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned TW    = cnt_width(MAX_T);

  phase_e           r_phase, w_phase_nxt;
  logic [DW-1:0]    r_dir, w_dir_nxt, w_dir_inc;
  logic [N_DIR-1:0] r_pending, w_pending_nxt;
  logic [N_DIR-1:0] w_dir_oh, w_req_acc;
  logic             r_blink, w_blink_nxt;
  logic             w_timer_clr, w_at_term, w_tick_term, w_others_pending;
  logic [TW-1:0]    w_term, w_count;

  tlc_phase_timer #(.W(TW)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clear   (w_timer_clr),
    .i_load    (1'b0),
    .i_load_val('0),
    .i_tick    (tick_en),
    .i_term    (w_term),
    .o_count   (w_count),
    .o_at_term (w_at_term)
  );

  assign w_dir_oh         = N_DIR'(1) << r_dir;
  assign w_dir_inc        = (r_dir == DW'(N_DIR - 1)) ? '0 : r_dir + 1'b1;
  assign w_tick_term      = tick_en & w_at_term;
  assign w_others_pending = |(r_pending & ~w_dir_oh);
  // Requests for the approach currently showing green/yellow are dropped.
  assign w_req_acc        = ((r_phase == PH_GREEN) || (r_phase == PH_YELLOW)) ?
                            (req & ~w_dir_oh) : req;

  // State register: phase, served approach, latched requests, blink.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase   <= PH_ALL_RED;
      r_dir     <= DW'(N_DIR - 1);
      r_pending <= '0;
      r_blink   <= 1'b0;
    end else begin
      r_phase   <= w_phase_nxt;
      r_dir     <= w_dir_nxt;
      r_pending <= w_pending_nxt;
      r_blink   <= w_blink_nxt;
    end
  end

  // Next-state logic; flash entry overrides every timed transition.
  always_comb begin
    w_phase_nxt   = r_phase;
    w_dir_nxt     = r_dir;
    w_blink_nxt   = r_blink;
    w_pending_nxt = r_pending | w_req_acc;
    w_timer_clr   = 1'b0;
    w_term        = '0;
    unique case (r_phase)
      PH_ALL_RED: begin
        w_term = TW'(ALL_RED_TICKS - 1);
        if (w_tick_term) begin
          w_phase_nxt   = PH_GREEN;
          w_dir_nxt     = w_dir_inc;
          // The clear of the newly served bit beats a same-cycle set.
          w_pending_nxt = w_pending_nxt & ~(N_DIR'(1) << w_dir_inc);
        end
      end
      PH_GREEN: begin
        w_term = TW'(GREEN_TICKS - 1);
        if (tick_en && (w_at_term ||
            ((w_count >= TW'(MIN_GREEN_TICKS - 1)) && w_others_pending))) begin
          w_phase_nxt = PH_YELLOW;
        end
      end
      PH_YELLOW: begin
        w_term = TW'(YELLOW_TICKS - 1);
        if (w_tick_term) w_phase_nxt = PH_ALL_RED;
      end
      PH_FLASH: begin
        w_term = TW'(FLASH_TICKS - 1);
        if (w_tick_term) begin
          w_blink_nxt = ~r_blink;
          w_timer_clr = 1'b1;
        end
        if (!flash_mode) w_phase_nxt = PH_ALL_RED;
      end
    endcase
    if (flash_mode && (r_phase != PH_FLASH)) begin
      w_phase_nxt = PH_FLASH;
      w_blink_nxt = 1'b1;
    end
    if (w_phase_nxt != r_phase) w_timer_clr = 1'b1;
  end

  // Lamp decode from registered state only.
  always_comb begin
    red    = '0;
    yellow = '0;
    green  = '0;
    unique case (r_phase)
      PH_ALL_RED: red = '1;
      PH_GREEN: begin
        green = w_dir_oh;
        red   = ~w_dir_oh;
      end
      PH_YELLOW: begin
        yellow = w_dir_oh;
        red    = ~w_dir_oh;
      end
      PH_FLASH: yellow = {N_DIR{r_blink}};
    endcase
  end

  assign active_dir = r_dir;
  assign phase      = r_phase;

endmodule

// File: tb/tb_traffic_intersection_controller.sv
// Self-checking bench: table of per-cycle expectations plus hand sequences
// for tick_en throttling and asynchronous reset.
module tb_traffic_intersection_controller;

  typedef struct packed {
    logic [1:0] red;
    logic [1:0] yel;
    logic [1:0] grn;
    logic       dir;
    logic [1:0] ph;
  } out_t;

  typedef struct {
    logic        te;
    logic [1:0]  rq;
    logic        fl;
    out_t        exp;
    int unsigned n;
  } vec_t;

  logic       clk, reset_n, tick_en, flash_mode;
  logic [1:0] req, red, yellow, green, phase;
  logic [0:0] active_dir;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned stepno = 0;
  out_t        sb[$];
  vec_t        tbl[$];

  traffic_intersection_controller #(
    .N_DIR(2), .GREEN_TICKS(8), .MIN_GREEN_TICKS(4),
    .YELLOW_TICKS(3), .ALL_RED_TICKS(2), .FLASH_TICKS(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tick_en(tick_en), .req(req),
    .flash_mode(flash_mode), .red(red), .yellow(yellow), .green(green),
    .active_dir(active_dir), .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t mk(input logic [1:0] r, input logic [1:0] y,
                              input logic [1:0] g, input logic d, input logic [1:0] p);
    out_t o;
    o.red = r; o.yel = y; o.grn = g; o.dir = d; o.ph = p;
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.red = red; o.yel = yellow; o.grn = green; o.dir = active_dir[0]; o.ph = phase;
    return o;
  endfunction

  task automatic compare(input string tag, input out_t e);
    out_t got;
    got = sample();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s step=%0d got red=%b yel=%b grn=%b dir=%0d ph=%0d want red=%b yel=%b grn=%b dir=%0d ph=%0d",
               tag, stepno, got.red, got.yel, got.grn, got.dir, got.ph,
               e.red, e.yel, e.grn, e.dir, e.ph);
    end
  endtask

  // Called at a falling edge: drive, queue expectation, check after next rising edge.
  task automatic step(input string tag, input logic te, input logic [1:0] rq,
                      input logic fl, input out_t e);
    tick_en = te; req = rq; flash_mode = fl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    stepno++;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s step=%0d scoreboard empty", tag, stepno);
    end else begin
      compare(tag, sb.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic add(input logic te, input logic [1:0] rq, input logic fl,
                     input out_t e, input int unsigned n);
    vec_t v;
    v.te = te; v.rq = rq; v.fl = fl; v.exp = e; v.n = n;
    tbl.push_back(v);
  endtask

  // Safety: at most one green, and never green together with yellow.
  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (!$onehot0(green) || ((|green) && (|yellow))) begin
        errors++;
        $display("FAIL safety green=%b yellow=%b", green, yellow);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    out_t AR0, AR1, G0, G1, Y0, Y1, FON0, FOFF0, RST;
    AR0   = mk(2'b11, 2'b00, 2'b00, 1'b0, 2'd0);
    AR1   = mk(2'b11, 2'b00, 2'b00, 1'b1, 2'd0);
    G0    = mk(2'b10, 2'b00, 2'b01, 1'b0, 2'd1);
    G1    = mk(2'b01, 2'b00, 2'b10, 1'b1, 2'd1);
    Y0    = mk(2'b10, 2'b01, 2'b00, 1'b0, 2'd2);
    Y1    = mk(2'b01, 2'b10, 2'b00, 1'b1, 2'd2);
    FON0  = mk(2'b00, 2'b11, 2'b00, 1'b0, 2'd3);
    FOFF0 = mk(2'b00, 2'b00, 2'b00, 1'b0, 2'd3);
    RST   = AR1;

    // Plain rotation, 26 cycles per round.
    add(1, 2'b00, 0, AR1, 1);
    add(1, 2'b00, 0, G0, 8);
    add(1, 2'b00, 0, Y0, 3);
    add(1, 2'b00, 0, AR0, 2);
    add(1, 2'b00, 0, G1, 8);
    add(1, 2'b00, 0, Y1, 3);
    add(1, 2'b00, 0, AR1, 2);
    // req[1] pulse in dir0 green cycle 1: green cut to 4 cycles.
    add(1, 2'b00, 0, G0, 1);
    add(1, 2'b10, 0, G0, 1);
    add(1, 2'b00, 0, G0, 2);
    add(1, 2'b00, 0, Y0, 3);
    add(1, 2'b00, 0, AR0, 2);
    // Own-direction request during green/yellow is dropped; the entry-cycle
    // set collides with the clear and loses. Dir1 keeps a full green.
    add(1, 2'b10, 0, G1, 8);
    add(1, 2'b10, 0, Y1, 3);
    add(1, 2'b00, 0, AR1, 2);
    // Dir0 green (req[0] ignored), req[1] in cycle 6 past minimum.
    add(1, 2'b01, 0, G0, 6);
    add(1, 2'b10, 0, G0, 1);
    add(1, 2'b00, 0, Y0, 3);
    add(1, 2'b00, 0, AR0, 2);
    add(1, 2'b00, 0, G1, 8);
    add(1, 2'b00, 0, Y1, 3);
    add(1, 2'b00, 0, AR1, 2);
    add(1, 2'b00, 0, G0, 1);
    // Flash mid-green, blink 4 on / 4 off, then exit to next approach.
    add(1, 2'b00, 1, FON0, 4);
    add(1, 2'b00, 1, FOFF0, 4);
    add(1, 2'b00, 1, FON0, 2);
    add(1, 2'b00, 0, AR0, 2);
    add(1, 2'b00, 0, G1, 1);

    tick_en = 1'b0; req = 2'b00; flash_mode = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    compare("reset_hold", RST);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      for (int unsigned k = 0; k < tbl[i].n; k++) begin
        step($sformatf("row%0d", i), tbl[i].te, tbl[i].rq, tbl[i].fl, tbl[i].exp);
      end
    end

    // tick_en one cycle in four; req[0] latched on a non-tick cycle cuts
    // dir1 green to 4 ticks, dir0 then gets the full 32-cycle green.
    for (int unsigned s = 0; s < 70; s++) begin
      out_t e;
      if (s < 15)      e = G1;
      else if (s < 27) e = Y1;
      else if (s < 35) e = AR1;
      else if (s < 67) e = G0;
      else             e = Y0;
      step("slow_tick", ((s % 4) == 3), (s == 1) ? 2'b01 : 2'b00, 1'b0, e);
    end

    // Asynchronous reset between edges during dir0 yellow.
    #2;
    reset_n = 1'b0;
    #1;
    compare("async_reset", RST);
    @(negedge clk);
    reset_n = 1'b1;
    step("post_reset", 1, 2'b00, 0, AR1);
    step("post_reset", 1, 2'b00, 0, G0);
    step("post_reset", 1, 2'b00, 0, G0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_intersection_controller.md
Name: traffic_intersection_controller

Overview:
Parametrised multi-direction traffic-light sequencer that succeeds the single-signal traffic_light_controller. It drives one red/yellow/green triple per approach and runs a round-robin sequence: green, then yellow, then all-red clearance, then the next approach. It adds tick-enable timing, latched pedestrian/vehicle requests that cut green short after a minimum time, and a flash (fault/night) mode. It sits below the intersection top level and is fed by a shared prescaler tick.

Parameters:
N_DIR, 2, number of approaches (>=2)
GREEN_TICKS, 8, maximum green duration in ticks (>=1)
MIN_GREEN_TICKS, 4, minimum green before a request can end it (1..GREEN_TICKS)
YELLOW_TICKS, 3, yellow duration in ticks (>=1)
ALL_RED_TICKS, 2, all-red clearance duration in ticks (>=1)
FLASH_TICKS, 4, half-period of the flash blink in ticks (>=1)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
tick_en  in  1  timing strobe; timers advance only on cycles where it is 1
req  in  N_DIR  per-approach service request, level or pulse
flash_mode  in  1  1 = enter/hold flash mode
red  out  N_DIR  red lamp per approach
yellow  out  N_DIR  yellow lamp per approach
green  out  N_DIR  green lamp per approach
active_dir  out  $clog2(N_DIR)  approach currently or most recently served
phase  out  2  0=ALL_RED 1=GREEN 2=YELLOW 3=FLASH

Behaviour:
- Reset (async assert, sync release): phase=ALL_RED, timer=0, active_dir=N_DIR-1, pending=0, blink=0, red=all 1, yellow=0, green=0.
- Outputs decode from registered state only; no input-to-output combinational path.
- Timer: width $clog2(max tick param + 1). It is cleared on every phase change and increments on tick_en cycles otherwise.
- ALL_RED: red=all 1. On a tick with timer==ALL_RED_TICKS-1: go to GREEN, active_dir <= (active_dir+1) mod N_DIR (wraps N_DIR-1 to 0), and clear pending[new dir].
- GREEN: green[active_dir]=1, red on all others. On a tick with timer==GREEN_TICKS-1, go to YELLOW.
- GREEN early exit: on a tick with timer>=MIN_GREEN_TICKS-1 and any pending bit set for a direction other than active_dir, go to YELLOW.
- YELLOW: yellow[active_dir]=1, red on others. On a tick with timer==YELLOW_TICKS-1, go to ALL_RED.
- Pending: pending[i] is set by req[i]=1 on any clock, regardless of tick_en.
  - req for active_dir during GREEN or YELLOW is ignored.
  - When a set and a clear hit the same bit in the same cycle, the clear wins.
  - Pending does not reorder service; it only shortens the current green. Round-robin order is fixed.
- FLASH: flash_mode=1 in any phase takes effect on the next edge, ignoring tick_en. In FLASH: red=0, green=0, yellow=all blink; blink toggles every FLASH_TICKS ticks, starts at 1 on entry, timer restarts each toggle.
- FLASH exit: when flash_mode=0, next edge goes to ALL_RED with timer=0. active_dir and pending are retained, so service resumes with the next approach.
- Safety invariant: at most one green bit set, and never green and yellow together. The invariant is asserted in the bench.
- Reset asserted mid-phase: all outputs return to reset values immediately (asynchronous).

Decomposition:
- Package tlc_pkg holds the phase encodings (PH_ALL_RED, PH_GREEN, PH_YELLOW, PH_FLASH) and a clog2-based width helper constant function.
- Sub-module tlc_phase_timer: a loadable tick counter with clear, tick_en and a terminal-count compare. It is instantiated once and reused for all phases and the blink.

Test Plan:
- Defaults, tick_en=1, reset released at t0: green becomes 2'b01 after the 2nd edge, lasts 8 cycles, then yellow=01 for 3, then red=11 for 2, then green=10. Full rotation is 26 cycles, and the one-hot-green assertion never fires.
- req[1] pulsed 1 cycle in dir0 green cycle 1: green[0] lasts exactly 4 cycles, then yellow. pending[1] clears on dir1 green entry.
- req[1] held during dir0 green cycle 6 (past MIN): yellow follows on the next edge. req[0] during dir0 green is ignored, and dir1 still gets a full 8-cycle green.
- tick_en at 1 cycle in 4: every phase lasts 4x its tick count (green=32 cycles). req is still latched on non-tick cycles.
- flash_mode=1 mid-green: next edge gives red=0, green=0, yellow=11 for 4 cycles then 00 for 4, repeating. On deassert: ALL_RED for 2 cycles, then green on the next direction.
- reset_n low mid-yellow, asynchronously between edges: red=11 and yellow=0 immediately. After release, dir0 green follows 2 edges later.
